mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_pkg.sv | 17 +
 rtl/mul_pipe_u15x14.sv | 29 ++
 rtl/mul_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared constants and FSM state type for the shared-multiplier arbiter.
package mul_share_pkg;

  localparam int unsigned A_W        = 15;
  localparam int unsigned B_W        = 14;
  localparam int unsigned P_W        = A_W + B_W;
  localparam int unsigned LATENCY    = 4;
  // Register stages inside mul_pipe_u15x14; the arbiter adds one issue stage.
  localparam int unsigned MUL_STAGES = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/mul_pipe_u15x14.sv
// Unsigned 15x14 pipelined multiplier: operand, product and output registers.
module mul_pipe_u15x14
  import mul_share_pkg::*;
(
  input  logic           clk,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] prod_q;
  logic [P_W-1:0] out_q;

  // Data path only; validity is tracked by the caller's tag pipeline.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q    <= a;
      b_q    <= b;
      prod_q <= P_W'(a_q) * P_W'(b_q);
      out_q  <= prod_q;
    end
  end

  assign p = out_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = mul_share_pkg::LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]         rsp_p,
  output logic                   idle
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;
  logic            issue;
  logic            retire;
  logic [CntW-1:0] inflight_q, inflight_d;

  logic [LATENCY-1:0] tag_vld_q;
  logic [IdxW-1:0]    tag_idx_q [LATENCY];

  logic [A_W-1:0] iss_a_q;
  logic [B_W-1:0] iss_b_q;
  logic [P_W-1:0] pipe_p;
  logic           rsp_seen_q;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int unsigned scan;
    scan    = 0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = (32'(ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = IdxW'(scan);
      end
    end
  end

  assign issue  = (state_q == StRun) && gnt_any;
  assign retire = tag_vld_q[LATENCY-1];

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; DRAIN leaves once the last product retires this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      StDrain: if (inflight_d == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
    end
    idle = (state_q == StIdle) && (inflight_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      rsp_seen_q <= 1'b0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      tag_vld_q    <= {tag_vld_q[LATENCY-2:0], issue};
      tag_idx_q[0] <= gnt_idx;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      if (retire) begin
        rsp_seen_q <= 1'b1;
      end
    end
  end

  // Issue register holds its operands between handshakes, so the free-running
  // pipe settles on the last product and rsp_p keeps that value when idle.
  always_ff @(posedge clk) begin
    if (issue) begin
      iss_a_q <= req_a[32'(gnt_idx)*A_W +: A_W];
      iss_b_q <= req_b[32'(gnt_idx)*B_W +: B_W];
    end
  end

  mul_pipe_u15x14 u_mul (
    .clk (clk),
    .ce  (1'b1),
    .a   (iss_a_q),
    .b   (iss_b_q),
    .p   (pipe_p)
  );

  assign rsp_valid = retire ? (NUM_REQ'(1) << tag_idx_q[LATENCY-1]) : '0;
  assign rsp_p     = (retire || rsp_seen_q) ? pipe_p : '0;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed, table-driven bench for mul_share_arbiter plus reset/drain sequences.
module tb_mul_share_arbiter;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [59:0] req_a;
  logic [55:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [28:0] rsp_p;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [59:0] a;
    logic [55:0] b;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [28:0] p;
    logic        idle;
  } vec_t;

  vec_t vecs[$];

  mul_share_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] pa(input int unsigned a3, a2, a1, a0);
    return {15'(a3), 15'(a2), 15'(a1), 15'(a0)};
  endfunction

  function automatic logic [55:0] pb(input int unsigned b3, b2, b1, b0);
    return {14'(b3), 14'(b2), 14'(b1), 14'(b0)};
  endfunction

  task automatic add(input logic en_i, input logic [3:0] v, input logic [59:0] a,
                     input logic [55:0] b, input logic [3:0] rdy, input logic [3:0] rsp,
                     input logic [28:0] p, input logic idl);
    vec_t r;
    r.en = en_i; r.v = v; r.a = a; r.b = b;
    r.rdy = rdy; r.rsp = rsp; r.p = p; r.idle = idl;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [59:0] sa;
  logic [55:0] sb;
  logic [3:0]  onehot [4];
  logic [28:0] prod [4];

  initial begin
    onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b0100; onehot[3] = 4'b1000;
    prod[0] = 29'd6; prod[1] = 29'd12; prod[2] = 29'd20; prod[3] = 29'd30;
    sa = pa(5, 4, 3, 2);
    sb = pb(6, 5, 4, 3);

    // Row 0: IDLE with en=1, moves to RUN next cycle.
    add(1, 4'b0000, sa, sb, 4'b0000, 4'b0000, 0, 1);
    // Rows 1-8: all four valid -> grants 0,1,2,3,0,1,2,3; responses 4 cycles later.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) add(1, 4'b1111, sa, sb, onehot[i % 4], 4'b0000, 0, 0);
      else       add(1, 4'b1111, sa, sb, onehot[i % 4], onehot[i % 4], prod[i % 4], 0);
    end
    for (int i = 0; i < 4; i++) add(1, 4'b0000, sa, sb, 4'b0000, onehot[i], prod[i], 0);
    add(1, 4'b0000, sa, sb, 4'b0000, 4'b0000, 0, 0);
    // Rows 14-19: single request 3*5, response exactly 4 cycles later only.
    add(1, 4'b0001, pa(0, 0, 0, 3), pb(0, 0, 0, 5), 4'b0001, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0001, 29'd15, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // Rows 20-24: maximum operands on requester 1.
    add(1, 4'b0010, pa(0, 0, 32767, 0), pb(0, 0, 16383, 0), 4'b0010, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0010, 29'd536821761, 0);
    // Rows 25-32: pointer reaches 3; lone req2 still granted and pointer stays 3.
    add(1, 4'b0100, pa(0, 7, 0, 0), pb(0, 9, 0, 0), 4'b0100, 4'b0000, 0, 0);
    add(1, 4'b0100, pa(0, 100, 0, 0), pb(0, 200, 0, 0), 4'b0100, 4'b0000, 0, 0);
    add(1, 4'b1111, pa(1000, 0, 0, 0), pb(3, 0, 0, 0), 4'b1000, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0100, 29'd63, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0100, 29'd20000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b1000, 29'd3000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // Rows 33-41: three issues, en falls with the third, drain then idle.
    add(1, 4'b1111, sa, sb, 4'b0001, 4'b0000, 0, 0);
    add(1, 4'b1111, sa, sb, 4'b0010, 4'b0000, 0, 0);
    add(0, 4'b1111, sa, sb, 4'b0100, 4'b0000, 0, 0);
    add(0, 4'b1111, sa, sb, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b1111, sa, sb, 4'b0000, 4'b0001, 29'd6, 0);
    add(0, 4'b1111, sa, sb, 4'b0000, 4'b0010, 29'd12, 0);
    add(0, 4'b1111, sa, sb, 4'b0000, 4'b0100, 29'd20, 0);
    add(0, 4'b1111, sa, sb, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b0000, sa, sb, 4'b0000, 4'b0000, 0, 1);

    // Reset state
    reset = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #2;
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_p", 32'(rsp_p), 0);
    check("reset idle", 32'(idle), 1);
    tick;
    tick;
    reset = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; req_valid = vecs[i].v; req_a = vecs[i].a; req_b = vecs[i].b;
      #3;
      check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rsp));
      check($sformatf("row%0d idle", i), 32'(idle), 32'(vecs[i].idle));
      if (vecs[i].rsp != 4'b0000)
        check($sformatf("row%0d rsp_p", i), 32'(rsp_p), 32'(vecs[i].p));
      tick;
    end

    // Reset with two products in flight: they must never retire.
    en = 1'b1; req_valid = 4'b0000;
    #3;
    check("pre-rst idle", 32'(idle), 1);
    tick;
    req_valid = 4'b0001; req_a = pa(0, 0, 0, 5); req_b = pb(0, 0, 0, 5);
    #3;
    check("pre-rst grant0", 32'(req_ready), 32'(4'b0001));
    tick;
    #3;
    check("pre-rst grant1", 32'(req_ready), 32'(4'b0001));
    tick;
    req_valid = 4'b0000;
    reset = 1'b0;
    #1;
    check("mid-rst req_ready", 32'(req_ready), 0);
    check("mid-rst rsp_valid", 32'(rsp_valid), 0);
    check("mid-rst rsp_p", 32'(rsp_p), 0);
    check("mid-rst idle", 32'(idle), 1);
    tick;
    reset = 1'b1; en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("post-rst c%0d rsp_valid", i), 32'(rsp_valid), 0);
      check($sformatf("post-rst c%0d idle", i), 32'(idle), 1);
      tick;
    end
    // Pointer must be back at 0.
    en = 1'b1;
    tick;
    req_valid = 4'b1111; req_a = sa; req_b = sb;
    #3;
    check("post-rst ptr grant", 32'(req_ready), 32'(4'b0001));
    tick;
    req_valid = 4'b0000; en = 1'b0;
    repeat (6) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
